// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// Module   : lfsr_pkg
// Brief    : Default Galois tap masks per width and LFSR helper functions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

    // Masks encode the non-constant, non-leading terms of a primitive polynomial.
    localparam logic [15:0] c_taps_w3  = 16'h0002;  // x^3+x+1
    localparam logic [15:0] c_taps_w4  = 16'h0002;  // x^4+x+1
    localparam logic [15:0] c_taps_w5  = 16'h0004;  // x^5+x^2+1
    localparam logic [15:0] c_taps_w6  = 16'h0002;  // x^6+x+1
    localparam logic [15:0] c_taps_w7  = 16'h0002;  // x^7+x+1
    localparam logic [15:0] c_taps_w8  = 16'h001C;  // x^8+x^4+x^3+x^2+1
    localparam logic [15:0] c_taps_w9  = 16'h0010;  // x^9+x^4+1
    localparam logic [15:0] c_taps_w10 = 16'h0008;  // x^10+x^3+1
    localparam logic [15:0] c_taps_w11 = 16'h0004;  // x^11+x^2+1
    localparam logic [15:0] c_taps_w12 = 16'h0052;  // x^12+x^6+x^4+x+1
    localparam logic [15:0] c_taps_w13 = 16'h001A;  // x^13+x^4+x^3+x+1
    localparam logic [15:0] c_taps_w14 = 16'h0442;  // x^14+x^10+x^6+x+1
    localparam logic [15:0] c_taps_w15 = 16'h0002;  // x^15+x+1
    localparam logic [15:0] c_taps_w16 = 16'h100A;  // x^16+x^12+x^3+x+1

    function automatic logic [15:0] default_taps(input int unsigned w);
        logic [15:0] taps;
        taps = c_taps_w5;
        case (w)
            3:       taps = c_taps_w3;
            4:       taps = c_taps_w4;
            5:       taps = c_taps_w5;
            6:       taps = c_taps_w6;
            7:       taps = c_taps_w7;
            8:       taps = c_taps_w8;
            9:       taps = c_taps_w9;
            10:      taps = c_taps_w10;
            11:      taps = c_taps_w11;
            12:      taps = c_taps_w12;
            13:      taps = c_taps_w13;
            14:      taps = c_taps_w14;
            15:      taps = c_taps_w15;
            16:      taps = c_taps_w16;
            default: taps = c_taps_w5;
        endcase
        return taps;
    endfunction

    function automatic int unsigned max_period(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_next.sv
// ----------------------------------------------------------------------------
// Module   : lfsr_next
// Brief    : Combinational single-step Galois LFSR successor function.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_next #(
    parameter int unsigned          WIDTH = 5,
    parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(5'b00100)
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq
);

    logic w_fb;

    assign w_fb  = q[WIDTH-1];
    assign nq[0] = w_fb;

    for (genvar i = 1; i < WIDTH; i++) begin : g_stage
        assign nq[i] = q[i-1] ^ (TAPS[i] & w_fb);
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ----------------------------------------------------------------------------
// Module   : lfsr_gen
// Brief    : Parametrised Galois LFSR with step enable, seed load, zero-seed
//            protection and measured-period reporting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_ref_seed;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_nq;
    logic             w_seed_zero;
    logic             w_hit_ref;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .q  (r_q),
        .nq (w_nq)
    );

    assign w_seed_zero = (seed_in == '0);
    assign w_hit_ref   = (w_nq == r_ref_seed);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_q        <= SEED;
            r_ref_seed <= SEED;
            r_cnt      <= '0;
            r_period   <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            // A zero seed would lock the register at zero forever.
            r_q        <= w_seed_zero ? SEED : seed_in;
            r_ref_seed <= w_seed_zero ? SEED : seed_in;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= w_seed_zero;
        end else if (en) begin
            r_q        <= w_nq;
            r_load_err <= 1'b0;
            if (w_hit_ref) begin
                r_period <= r_cnt + c_one;
                r_cnt    <= '0;
                r_wrap   <= 1'b1;
            end else begin
                r_cnt    <= r_cnt + c_one;
                r_wrap   <= 1'b0;
            end
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign q        = r_q;
    assign bit_out  = r_q[WIDTH-1];
    assign wrap     = r_wrap;
    assign period   = r_period;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ----------------------------------------------------------------------------
// Module   : tb_lfsr_gen
// Brief    : Self-checking bench for lfsr_gen (WIDTH=5, x^5+x^2+1, SEED=all ones).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_gen;
    import lfsr_pkg::*;

    localparam int unsigned c_w = 5;

    typedef struct {
        logic           load;
        logic           en;
        logic [c_w-1:0] seed_in;
        logic [c_w-1:0] exp_q;
        logic           exp_wrap;
        logic           exp_err;
        logic [c_w-1:0] exp_period;
    } vec_t;

    logic           clk;
    logic           clk_run;
    logic           rst_b;
    logic           en;
    logic           load;
    logic [c_w-1:0] seed_in;
    logic [c_w-1:0] q;
    logic           bit_out;
    logic           wrap;
    logic [c_w-1:0] period;
    logic           load_err;

    int checks;
    int failures;

    lfsr_gen #(
        .WIDTH (c_w),
        .TAPS  (5'b00100),
        .SEED  (5'b11111)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .load     (load),
        .seed_in  (seed_in),
        .q        (q),
        .bit_out  (bit_out),
        .wrap     (wrap),
        .period   (period),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden successor written from the polynomial x^5+x^2+1.
    function automatic logic [c_w-1:0] model_step(input logic [c_w-1:0] s);
        logic [c_w-1:0] n;
        n = {s[3:0], 1'b0};
        if (s[4]) n = n ^ 5'b00101;
        return n;
    endfunction

    task automatic cycle(input logic l, input logic e, input logic [c_w-1:0] s);
        load    = l;
        en      = e;
        seed_in = s;
        @(posedge clk);
        #1;
    endtask

    // Steps from the current state with en held; expects wrap only on the last step.
    task automatic run_period(input string tag, input logic [c_w-1:0] start);
        logic [c_w-1:0] m;
        logic           seen [32];
        int             n;
        n = int'(max_period(c_w));
        m = start;
        for (int k = 0; k < 32; k++) seen[k] = 1'b0;
        for (int i = 1; i <= n; i++) begin
            cycle(1'b0, 1'b1, '0);
            m = model_step(m);
            chk({tag, "_q"}, 32'(q), 32'(m));
            chk({tag, "_wrap"}, 32'(wrap), 32'(i == n));
            chk({tag, "_fresh"}, 32'(seen[q] || q == '0), 32'd0);
            seen[q] = 1'b1;
        end
        chk({tag, "_endq"}, 32'(q), 32'(start));
        chk({tag, "_period"}, 32'(period), 32'(n));
    endtask

    vec_t vecs [9];

    initial begin
        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        seed_in  = '0;
        rst_b    = 1'b1;
        #2 rst_b = 1'b0;
        #2;
        chk("rst_q", 32'(q), 32'h1F);
        chk("rst_bit_out", 32'(bit_out), 32'd1);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        rst_b   = 1'b1;
        clk_run = 1'b1;

        //            load  en    seed      q         wrap  err   period
        vecs[0] = '{1'b0, 1'b1, 5'h00, 5'b11011, 1'b0, 1'b0, 5'd0};
        vecs[1] = '{1'b0, 1'b1, 5'h00, 5'b10011, 1'b0, 1'b0, 5'd0};
        vecs[2] = '{1'b0, 1'b0, 5'h00, 5'b10011, 1'b0, 1'b0, 5'd0};
        vecs[3] = '{1'b1, 1'b0, 5'h00, 5'b11111, 1'b0, 1'b1, 5'd0};
        vecs[4] = '{1'b0, 1'b0, 5'h00, 5'b11111, 1'b0, 1'b0, 5'd0};
        vecs[5] = '{1'b1, 1'b1, 5'h06, 5'b00110, 1'b0, 1'b0, 5'd0};
        vecs[6] = '{1'b1, 1'b0, 5'h01, 5'b00001, 1'b0, 1'b0, 5'd0};
        vecs[7] = '{1'b0, 1'b1, 5'h00, 5'b00010, 1'b0, 1'b0, 5'd0};
        vecs[8] = '{1'b0, 1'b1, 5'h00, 5'b00100, 1'b0, 1'b0, 5'd0};

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].load, vecs[i].en, vecs[i].seed_in);
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_bit_out", i), 32'(bit_out), 32'(vecs[i].exp_q[c_w-1]));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d_load_err", i), 32'(load_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_period", i), 32'(period), 32'(vecs[i].exp_period));
        end

        // Full period from reset, then hold with en low.
        rst_b = 1'b0;
        #1 rst_b = 1'b1;
        run_period("full", 5'b11111);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            chk("hold_q", 32'(q), 32'h1F);
            chk("hold_wrap", 32'(wrap), 32'd0);
            chk("hold_period", 32'(period), 32'd31);
        end

        // Loaded seed becomes the wrap reference; load leaves period alone.
        cycle(1'b1, 1'b0, 5'b00001);
        chk("ld1_q", 32'(q), 32'h01);
        chk("ld1_period_kept", 32'(period), 32'd31);
        run_period("seed1", 5'b00001);

        // Mid-run async reset discards the loaded reference.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);
        rst_b = 1'b0;
        #1;
        chk("midrst_q", 32'(q), 32'h1F);
        chk("midrst_wrap", 32'(wrap), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        rst_b = 1'b1;
        run_period("post_rst", 5'b11111);

        cycle(1'b0, 1'b0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
